// File: rtl/fp_pipe_issue_ctrl_pkg.sv
// Shared types for the FP add/sub issue path.
//   exe_p_mux_bus_type : per-op control payload carried through the FP unit
//                        and handed to the EXE writeback mux.
//   FADD_LAT           : FP add/sub unit depth, issue to p_result.
package riscv_types;

  localparam int unsigned FADD_LAT = 3;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned TAG_W    = 8;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             FP_reg_write;
    logic             fp_sub;
    logic [TAG_W-1:0] tag;
  } exe_p_mux_bus_type;

endpackage

// File: rtl/fp_pipe_issue_ctrl_hazard.sv
// fp_hazard_cmp: RAW check of one source register against every unit stage.
//   rs, rs_fp, rs_use       : source index, FP/int register file select, read enable
//   uu_rd, uu_reg_write,
//   uu_FP_reg_write         : destination and write enables held in each stage
//   hit                     : some in-flight op will write the register this source reads
module fp_hazard_cmp
  import riscv_types::*;
#(
  parameter int unsigned LAT = FADD_LAT
) (
  input  logic [REG_W-1:0]          rs,
  input  logic                      rs_fp,
  input  logic                      rs_use,
  input  logic [LAT-1:0][REG_W-1:0] uu_rd,
  input  logic [LAT-1:0]            uu_reg_write,
  input  logic [LAT-1:0]            uu_FP_reg_write,
  output logic                      hit
);

  // Integer x0 is hard-wired to zero, so a pending write to it is never a hazard.
  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < LAT; k++) begin
      if (rs_use && (uu_rd[k] == rs)) begin
        if (rs_fp) begin
          hit = hit | uu_FP_reg_write[k];
        end else if (rs != '0) begin
          hit = hit | uu_reg_write[k];
        end
      end
    end
  end

endmodule

// File: rtl/fp_pipe_issue_ctrl.sv
// fp_pipe_issue_ctrl: issue-side controller for the pipelined FP add/sub unit.
// Stalls issue on RAW hazards against in-flight destinations, freezes the unit
// on writeback stall, kills in-flight work on flush and tracks occupancy.
//   clk, rst (async, active low)
//   issue_valid/issue_ready/issue_bus/issue_rs1/issue_rs2/issue_rs_fp/issue_rs_use : decode/issue side
//   flush, wb_stall                 : pipeline control
//   u_en, u_clear, u_p_start, u_bus : drive the unit
//   u_p_result, u_bus_o, uu_*       : observed from the unit
//   wb_valid, wb_bus                : result token to the EXE writeback mux
//   inflight, idle                  : occupancy
module fp_pipe_issue_ctrl
  import riscv_types::*;
#(
  parameter int unsigned LAT   = FADD_LAT,
  parameter int unsigned CNT_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  exe_p_mux_bus_type         issue_bus,
  input  logic [REG_W-1:0]          issue_rs1,
  input  logic [REG_W-1:0]          issue_rs2,
  input  logic [1:0]                issue_rs_fp,
  input  logic [1:0]                issue_rs_use,
  input  logic                      flush,
  input  logic                      wb_stall,
  output logic                      u_en,
  output logic [LAT-1:0]            u_clear,
  output logic                      u_p_start,
  output exe_p_mux_bus_type         u_bus,
  input  logic                      u_p_result,
  input  exe_p_mux_bus_type         u_bus_o,
  input  logic [LAT-1:0][REG_W-1:0] uu_rd,
  input  logic [LAT-1:0]            uu_reg_write,
  input  logic [LAT-1:0]            uu_FP_reg_write,
  output logic                      wb_valid,
  output exe_p_mux_bus_type         wb_bus,
  output logic [CNT_W-1:0]          inflight,
  output logic                      idle
);

  logic             hit_rs1;
  logic             hit_rs2;
  logic             hazard;
  logic             fire;
  logic             retire;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;

  // One comparator per source operand.
  fp_hazard_cmp #(.LAT(LAT)) u_cmp_rs1 (
    .rs              (issue_rs1),
    .rs_fp           (issue_rs_fp[0]),
    .rs_use          (issue_rs_use[0]),
    .uu_rd           (uu_rd),
    .uu_reg_write    (uu_reg_write),
    .uu_FP_reg_write (uu_FP_reg_write),
    .hit             (hit_rs1)
  );

  fp_hazard_cmp #(.LAT(LAT)) u_cmp_rs2 (
    .rs              (issue_rs2),
    .rs_fp           (issue_rs_fp[1]),
    .rs_use          (issue_rs_use[1]),
    .uu_rd           (uu_rd),
    .uu_reg_write    (uu_reg_write),
    .uu_FP_reg_write (uu_FP_reg_write),
    .hit             (hit_rs2)
  );

  assign hazard = hit_rs1 | hit_rs2;

  // Issue handshake and unit drive; stall-only, no bypass.
  always_comb begin
    issue_ready = rst & ~wb_stall & ~flush & ~hazard;
    fire        = issue_valid & issue_ready;
    u_p_start   = fire;
    u_bus       = fire ? issue_bus : '0;
    u_en        = ~wb_stall;
    // Clear outranks en inside the unit, so flush under stall still empties it.
    u_clear     = (flush & rst) ? '1 : '0;
    wb_valid    = u_p_result & ~flush;
    wb_bus      = u_bus_o;
    retire      = wb_valid & ~wb_stall;
  end

  // Occupancy next state; fire and retire together cancel.
  always_comb begin
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else begin
      case ({fire, retire})
        2'b10:   inflight_d = inflight_q + CNT_W'(1);
        2'b01:   inflight_d = inflight_q - CNT_W'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;
  assign idle     = (inflight_q == '0);

  // Counter must stay within 0..LAT.
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
    !(!flush && retire && !fire && (inflight_q == '0)));
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(!flush && fire && !retire && (inflight_q == CNT_W'(LAT))));

endmodule

// File: tb/tb_fp_pipe_issue_ctrl.sv
// Bench for fp_pipe_issue_ctrl with a behavioural 3-stage FP unit model.
module tb_fp_pipe_issue_ctrl;
  import riscv_types::*;

  localparam int unsigned LAT = 3;

  logic clk;
  logic rst;
  logic issue_valid, issue_ready;
  exe_p_mux_bus_type issue_bus;
  logic [4:0] issue_rs1, issue_rs2;
  logic [1:0] issue_rs_fp, issue_rs_use;
  logic flush, wb_stall;
  logic u_en;
  logic [LAT-1:0] u_clear;
  logic u_p_start;
  exe_p_mux_bus_type u_bus;
  logic u_p_result;
  exe_p_mux_bus_type u_bus_o;
  logic [LAT-1:0][4:0] uu_rd;
  logic [LAT-1:0] uu_reg_write, uu_FP_reg_write;
  logic wb_valid;
  exe_p_mux_bus_type wb_bus;
  logic [1:0] inflight;
  logic idle;

  int checks = 0;
  int failures = 0;

  fp_pipe_issue_ctrl #(.LAT(LAT), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_bus(issue_bus),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs_fp(issue_rs_fp), .issue_rs_use(issue_rs_use),
    .flush(flush), .wb_stall(wb_stall),
    .u_en(u_en), .u_clear(u_clear), .u_p_start(u_p_start), .u_bus(u_bus),
    .u_p_result(u_p_result), .u_bus_o(u_bus_o),
    .uu_rd(uu_rd), .uu_reg_write(uu_reg_write), .uu_FP_reg_write(uu_FP_reg_write),
    .wb_valid(wb_valid), .wb_bus(wb_bus), .inflight(inflight), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FP unit: clear beats en, en=0 holds every stage.
  logic              sv [LAT];
  exe_p_mux_bus_type sb [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) begin
        sv[k] <= 1'b0;
        sb[k] <= '0;
      end
    end else begin
      if (u_clear[0]) sv[0] <= 1'b0;
      else if (u_en) begin
        sv[0] <= u_p_start;
        sb[0] <= u_bus;
      end
      for (int k = 1; k < LAT; k++) begin
        if (u_clear[k]) sv[k] <= 1'b0;
        else if (u_en) begin
          sv[k] <= sv[k-1];
          sb[k] <= sb[k-1];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      uu_rd[k]           = sb[k].rd;
      uu_reg_write[k]    = sv[k] & sb[k].reg_write;
      uu_FP_reg_write[k] = sv[k] & sb[k].FP_reg_write;
    end
    u_p_result = sv[LAT-1];
    u_bus_o    = sb[LAT-1];
  end

  function automatic logic [7:0] tag_of(input logic [4:0] rd);
    return {3'b000, rd} ^ 8'hA5;
  endfunction

  function automatic exe_p_mux_bus_type mkbus(input logic [4:0] rd, input logic rw, input logic fw);
    exe_p_mux_bus_type b;
    b.rd = rd;
    b.reg_write = rw;
    b.FP_reg_write = fw;
    b.fp_sub = rd[0];
    b.tag = tag_of(rd);
    return b;
  endfunction

  typedef struct {
    logic       iv;
    logic [4:0] rd;
    logic       rw, fw;
    logic [4:0] rs1, rs2;
    logic [1:0] fp, use_;
    logic       fl, st;
    logic       rdy, uen;
    logic [2:0] clr;
    logic       wbv;
    logic [4:0] wbrd;
    logic [1:0] infl;
  } vec_t;

  function automatic vec_t mkv(
    input logic iv, input logic [4:0] rd, input logic rw, input logic fw,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] fp, input logic [1:0] use_,
    input logic fl, input logic st,
    input logic rdy, input logic uen, input logic [2:0] clr,
    input logic wbv, input logic [4:0] wbrd, input logic [1:0] infl);
    vec_t v;
    v.iv = iv; v.rd = rd; v.rw = rw; v.fw = fw; v.rs1 = rs1; v.rs2 = rs2;
    v.fp = fp; v.use_ = use_; v.fl = fl; v.st = st;
    v.rdy = rdy; v.uen = uen; v.clr = clr; v.wbv = wbv; v.wbrd = wbrd; v.infl = infl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t e;
    logic exp_start;
    int   lat;

    // iv rd rw fw rs1 rs2 fp use fl st | rdy uen clr wbv wbrd infl
    // back-to-back independent ops
    tbl.push_back(mkv(1, 1,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(1, 2,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 1));
    tbl.push_back(mkv(1, 3,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 2));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 1,1, 3));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 1,2, 2));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 1,3, 1));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    // FP RAW on f5
    tbl.push_back(mkv(1, 5,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(1, 6,0,1, 5,0,2'b01,2'b01, 0,0, 0,1,3'b000, 0,0, 1));
    tbl.push_back(mkv(1, 6,0,1, 5,0,2'b01,2'b01, 0,0, 0,1,3'b000, 0,0, 1));
    tbl.push_back(mkv(1, 6,0,1, 5,0,2'b01,2'b01, 0,0, 0,1,3'b000, 1,5, 1));
    tbl.push_back(mkv(1, 6,0,1, 5,0,2'b01,2'b01, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 1));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 1));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 1,6, 1));
    // x0 exemption, int-vs-FP file separation, real int hazard
    tbl.push_back(mkv(1, 0,1,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(1, 7,0,1, 0,0,2'b00,2'b01, 0,0, 1,1,3'b000, 0,0, 1));
    tbl.push_back(mkv(1, 8,1,0, 0,7,2'b00,2'b11, 0,0, 1,1,3'b000, 0,0, 2));
    tbl.push_back(mkv(1, 9,1,0, 8,0,2'b00,2'b01, 0,0, 0,1,3'b000, 1,0, 3));
    // wb_stall with two in flight
    tbl.push_back(mkv(1, 9,1,0, 0,0,2'b00,2'b00, 0,1, 0,0,3'b000, 1,7, 2));
    tbl.push_back(mkv(1, 9,1,0, 0,0,2'b00,2'b00, 0,1, 0,0,3'b000, 1,7, 2));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 1,7, 2));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 1,8, 1));
    // flush with three in flight
    tbl.push_back(mkv(1,10,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(1,11,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 1));
    tbl.push_back(mkv(1,12,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 2));
    tbl.push_back(mkv(1,13,0,1, 0,0,2'b00,2'b00, 1,0, 0,1,3'b111, 0,0, 3));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    // flush during wb_stall
    tbl.push_back(mkv(1,14,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(1,15,0,1, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 1));
    tbl.push_back(mkv(1,16,0,1, 0,0,2'b00,2'b00, 1,1, 0,0,3'b111, 0,0, 2));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));
    tbl.push_back(mkv(0, 0,0,0, 0,0,2'b00,2'b00, 0,0, 1,1,3'b000, 0,0, 0));

    // Reset state, with valid and flush asserted to show both are ignored.
    rst = 1'b0;
    issue_valid = 1'b1; issue_bus = mkbus(5'd4, 1'b1, 1'b0);
    issue_rs1 = '0; issue_rs2 = '0; issue_rs_fp = '0; issue_rs_use = '0;
    flush = 1'b1; wb_stall = 1'b0;
    #3;
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ready", 32'(issue_ready), 32'd0);
    chk("rst_start", 32'(u_p_start), 32'd0);
    chk("rst_bus", 32'(u_bus), 32'd0);
    chk("rst_clear", 32'(u_clear), 32'd0);
    @(negedge clk);
    rst = 1'b1; issue_valid = 1'b0; flush = 1'b0;

    foreach (tbl[i]) begin
      e = tbl[i];
      @(negedge clk);
      issue_valid = e.iv; issue_bus = mkbus(e.rd, e.rw, e.fw);
      issue_rs1 = e.rs1; issue_rs2 = e.rs2; issue_rs_fp = e.fp; issue_rs_use = e.use_;
      flush = e.fl; wb_stall = e.st;
      #1;
      exp_start = e.iv & e.rdy;
      chk($sformatf("c%0d_ready", i), 32'(issue_ready), 32'(e.rdy));
      chk($sformatf("c%0d_start", i), 32'(u_p_start), 32'(exp_start));
      chk($sformatf("c%0d_ubus", i), 32'(u_bus), exp_start ? 32'(mkbus(e.rd, e.rw, e.fw)) : 32'd0);
      chk($sformatf("c%0d_en", i), 32'(u_en), 32'(e.uen));
      chk($sformatf("c%0d_clear", i), 32'(u_clear), 32'(e.clr));
      chk($sformatf("c%0d_wbv", i), 32'(wb_valid), 32'(e.wbv));
      chk($sformatf("c%0d_inflight", i), 32'(inflight), 32'(e.infl));
      chk($sformatf("c%0d_idle", i), 32'(idle), 32'(e.infl == 2'd0));
      if (e.wbv) begin
        chk($sformatf("c%0d_wb_rd", i), 32'(wb_bus.rd), 32'(e.wbrd));
        chk($sformatf("c%0d_wb_tag", i), 32'(wb_bus.tag), 32'(tag_of(e.wbrd)));
      end
    end

    // Async reset mid-stream with two ops in flight.
    @(negedge clk);
    issue_valid = 1'b1; issue_bus = mkbus(5'd20, 1'b0, 1'b1);
    issue_rs_use = '0; flush = 1'b0; wb_stall = 1'b0;
    @(negedge clk);
    issue_bus = mkbus(5'd21, 1'b0, 1'b1);
    @(negedge clk);
    issue_bus = mkbus(5'd22, 1'b0, 1'b1);
    #1;
    chk("pre_rst_inflight", 32'(inflight), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_inflight", 32'(inflight), 32'd0);
    chk("arst_idle", 32'(idle), 32'd1);
    chk("arst_ready", 32'(issue_ready), 32'd0);
    chk("arst_start", 32'(u_p_start), 32'd0);
    chk("arst_bus", 32'(u_bus), 32'd0);
    issue_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_inflight", 32'(inflight), 32'd0);
    chk("post_rst_wbv", 32'(wb_valid), 32'd0);

    // First op after release sees full latency.
    @(negedge clk);
    issue_valid = 1'b1; issue_bus = mkbus(5'd23, 1'b0, 1'b1);
    #1;
    chk("lat_fire", 32'(u_p_start), 32'd1);
    lat = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      issue_valid = 1'b0;
      #1;
      if (wb_valid && lat == 0) begin
        lat = n;
        chk("lat_wb_rd", 32'(wb_bus.rd), 32'd23);
      end
    end
    chk("lat_cycles", 32'(lat), 32'(LAT));
    chk("lat_idle", 32'(idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
